quickq_node_store: RTL and testbench
====================================

Name: quickq_node_store

Overview:
- Storage-side responder for the QuickQ control state machine: owns one node's sorted BRAM array, the temp (swap) register and the input mux.
- Answers the controller's re/we/rd_addr/wr_addr/mode/mux1_sel requests with result, swap_done, done, full and empty.
- Sits between the QuickQ control FSM and the router data path; one instance per node.

Parameters:
- DATA_W, 32, key width; all-ones is the empty-slot sentinel.
- DEPTH, 16, slots per node (power of two, 2..256).
- ADDR_W, 32, controller address width; the low $clog2(DEPTH) bits index the array.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- re  in  1  read request; data valid next cycle
- we  in  1  swap request; level, held until swap_done
- rd_addr  in  ADDR_W  read slot index
- wr_addr  in  ADDR_W  swap slot index
- mode  in  3  000 load temp, 001 enq commit, 010 load sentinel, 011 deq commit, 100 idle
- mux1_sel  in  2  temp source: 00 din, 01 router_din, 10 sentinel, 11 hold
- din  in  DATA_W  host enqueue key
- router_din  in  DATA_W  key from neighbouring node
- result  out  1  temp < rd_data (swap needed)
- swap_done  out  1  one-cycle completion pulse
- done  out  1  rd_addr has reached count (end of occupied region)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- dout  out  DATA_W  current temp value (evicted or dequeued key)
- count  out  $clog2(DEPTH)+1  occupied slots
- err  out  1  sticky: overflow, underflow or out-of-range access
- swap_cnt  out  16  swap statistics; see Optional Feature

Behaviour:
- Reset (rst low, asynchronous):
  - temp = all-ones; rd_data = all-ones; valid bitmap = 0; count = 0.
  - swap_done = 0, err = 0, swap_cnt = 0; FSM in S_IDLE.
  - BRAM contents are not reset. Any slot whose valid bit is 0 reads as all-ones.
- Read: re=1 in cycle N registers mem[rd_addr] (or all-ones if the slot is invalid) into rd_data at N+1.
  - result = (temp < rd_data), unsigned, combinational from registers.
  - Read-first: a same-cycle write to the same slot returns the old data.
- Temp load: in mode 000 or 010, temp <= the mux1_sel source on every clock. mux1_sel=01 loads router_din in any mode. 11 holds.
- Swap FSM:
  - S_IDLE: on we=1 go to S_WRITE.
  - S_WRITE: mem[wr_addr] <= temp; temp <= old slot value (all-ones if invalid); valid bit <= (temp != all-ones). Go to S_DONE.
  - S_DONE: swap_done=1 for exactly one cycle; return to S_IDLE.
  - we is ignored outside S_IDLE. Worst case, we to swap_done latency is 2 cycles.
- Count:
  - Increments on the cycle mode changes into 001.
  - Decrements on the cycle mode changes into 011.
  - Increment at full is suppressed and sets err. Decrement at empty is suppressed and sets err.
  - full and empty are combinational from count.
- done = (rd_addr >= count).
- Out-of-range access (rd_addr or wr_addr >= DEPTH):
  - Reads return all-ones; the swap completes with no memory write.
  - err is set. err clears only on reset.
- Reset asserted mid-swap: the FSM returns to S_IDLE, no swap_done is issued, and the written slot is invalidated through the bitmap clear.

Optional Feature:
- Macro QUICKQ_NODE_STATS_EN.
- Defined: swap_cnt increments by 1 on every swap_done and saturates at 16'hFFFF.
- Undefined: swap_cnt is tied to 0 and no counter logic is built.

Decomposition:
- quickq_pkg holds:
  - mode_t enum (MODE_LOAD, MODE_ENQ_COMMIT, MODE_LOAD_SENT, MODE_DEQ_COMMIT, MODE_IDLE).
  - mux_sel_t enum.
  - swap_state_t enum (S_IDLE, S_WRITE, S_DONE).
  - Function sentinel(DATA_W).
- One sub-module: quickq_bram, a simple dual-port, read-first, 1-cycle-read RAM with no reset.

Test Plan:
- Reset, then re at addr 3: rd_data=all-ones, result=1 for temp=5, empty=1, count=0.
- Enqueue flow:
  - Stimulus: mode 000, din=7; re addr 0; we addr 0; mode 001.
  - Required: swap_done exactly 2 cycles after we; dout=all-ones; mem[0]=7; count=1.
- Enqueue 9 then 4:
  - Stimulus: swap 4 into slot 0; swap the evicted 9 into slot 1.
  - Required: the read sequence shows 4, 9.
- Fill to DEPTH=16, then another mode-001 edge: full=1, count stays 16, err=1.
- Dequeue at count=1:
  - Stimulus: mode 010, then swap slot 0, then mode 011.
  - Required: dout=7, empty=1, count=0.
- Assert rst mid-swap in S_WRITE: swap_done never pulses; all reads return all-ones; with QUICKQ_NODE_STATS_EN, swap_cnt=0.

Source files
------------

// File: rtl/quickq_pkg.sv
// Shared types for the QuickQ node store: controller modes, temp-source select,
// swap FSM states, and the all-ones empty-slot sentinel.
package quickq_pkg;

  typedef enum logic [2:0] {
    MODE_LOAD       = 3'b000,
    MODE_ENQ_COMMIT = 3'b001,
    MODE_LOAD_SENT  = 3'b010,
    MODE_DEQ_COMMIT = 3'b011,
    MODE_IDLE       = 3'b100
  } mode_t;

  typedef enum logic [1:0] {
    MUX_DIN    = 2'b00,
    MUX_ROUTER = 2'b01,
    MUX_SENT   = 2'b10,
    MUX_HOLD   = 2'b11
  } mux_sel_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_DONE  = 2'b10
  } swap_state_t;

  localparam int unsigned SENT_MAX_W = 256;

  // Low w bits set; callers slice to their key width.
  function automatic logic [SENT_MAX_W-1:0] sentinel(input int unsigned w);
    logic [SENT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SENT_MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/quickq_bram.sv
// Simple dual-port RAM: one write port, one read port, read-first, one-cycle
// registered read, no reset on contents or output register.
module quickq_bram #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/quickq_node_store.sv
// QuickQ per-node storage responder: sorted slot array, temp/swap register, input mux.
// Optional swap statistics counter built when QUICKQ_NODE_STATS_EN is defined.
module quickq_node_store
  import quickq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [2:0]               mode,
  input  logic [1:0]               mux1_sel,
  input  logic [DATA_W-1:0]        din,
  input  logic [DATA_W-1:0]        router_din,
  output logic                     result,
  output logic                     swap_done,
  output logic                     done,
  output logic                     full,
  output logic                     empty,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  output logic [15:0]              swap_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SENT_MAX_W-1:0] SENT_WIDE = sentinel(DATA_W);
  localparam logic [DATA_W-1:0]     SENT      = SENT_WIDE[DATA_W-1:0];
  localparam logic [ADDR_W-1:0]     DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);

  swap_state_t       r_state, w_state_next;
  logic [DATA_W-1:0] r_temp;
  logic [CW-1:0]     r_count;
  logic              r_err;
  logic [DEPTH-1:0]  r_valid;
  logic              r_rd_ok, r_sw_ok, r_sw_oor;
  logic [AW-1:0]     r_wr_idx;
  logic [2:0]        r_mode_prev;

  logic              w_rd_oor, w_wr_oor, w_swap_start, w_mem_we;
  logic              w_inc, w_dec, w_load;
  logic [AW-1:0]     w_rd_idx, w_wr_idx;
  logic [DATA_W-1:0] w_src, w_rd_data, w_old;
  logic              w_ren   [2];
  logic [AW-1:0]     w_raddr [2];
  logic [DATA_W-1:0] w_q     [2];

  assign w_rd_oor     = (rd_addr >= DEPTH_A);
  assign w_wr_oor     = (wr_addr >= DEPTH_A);
  assign w_rd_idx     = rd_addr[AW-1:0];
  assign w_wr_idx     = wr_addr[AW-1:0];
  assign w_swap_start = (r_state == S_IDLE) && we;
  assign w_inc        = (mode == MODE_ENQ_COMMIT) && (r_mode_prev != MODE_ENQ_COMMIT);
  assign w_dec        = (mode == MODE_DEQ_COMMIT) && (r_mode_prev != MODE_DEQ_COMMIT);

  // Two mirrored RAMs: port 0 serves controller reads, port 1 prefetches the swap slot.
  assign w_ren[0]   = re;
  assign w_raddr[0] = w_rd_idx;
  assign w_ren[1]   = w_swap_start;
  assign w_raddr[1] = w_wr_idx;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      quickq_bram #(.DATA_W(DATA_W), .AW(AW)) u_bram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_idx),
        .i_wdata (r_temp),
        .i_re    (w_ren[gi]),
        .i_raddr (w_raddr[gi]),
        .o_rdata (w_q[gi])
      );
    end
  endgenerate

  assign w_rd_data = r_rd_ok ? w_q[0] : SENT;
  assign w_old     = r_sw_ok ? w_q[1] : SENT;

  always_comb begin
    w_state_next = r_state;
    swap_done    = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE:  if (we) w_state_next = S_WRITE;
      S_WRITE: begin
        w_mem_we     = !r_sw_oor;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        swap_done    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_src = r_temp;
    case (mux1_sel)
      MUX_DIN:    w_src = din;
      MUX_ROUTER: w_src = router_din;
      MUX_SENT:   w_src = SENT;
      default:    w_src = r_temp;
    endcase
    w_load = (mode == MODE_LOAD) || (mode == MODE_LOAD_SENT) || (mux1_sel == MUX_ROUTER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_temp      <= SENT;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_valid     <= '0;
      r_rd_ok     <= 1'b0;
      r_sw_ok     <= 1'b0;
      r_sw_oor    <= 1'b0;
      r_wr_idx    <= '0;
      r_mode_prev <= MODE_IDLE;
    end else begin
      r_state     <= w_state_next;
      r_mode_prev <= mode;
      if (r_state == S_WRITE) r_temp <= w_old;
      else if (w_load)        r_temp <= w_src;
      if (w_mem_we) r_valid[r_wr_idx] <= (r_temp != SENT);
      if (re) r_rd_ok <= !w_rd_oor && r_valid[w_rd_idx];
      if (w_swap_start) begin
        r_wr_idx <= w_wr_idx;
        r_sw_ok  <= !w_wr_oor && r_valid[w_wr_idx];
        r_sw_oor <= w_wr_oor;
      end
      if (w_inc && !full)       r_count <= r_count + 1'b1;
      else if (w_dec && !empty) r_count <= r_count - 1'b1;
      if ((re && w_rd_oor) || (w_swap_start && w_wr_oor) ||
          (w_inc && full) || (w_dec && empty))
        r_err <= 1'b1;
    end
  end

  assign result = (r_temp < w_rd_data);
  assign dout   = r_temp;
  assign count  = r_count;
  assign full   = (r_count == DEPTH_C);
  assign empty  = (r_count == '0);
  assign done   = (rd_addr >= ADDR_W'(r_count));
  assign err    = r_err;

`ifdef QUICKQ_NODE_STATS_EN
  logic [15:0] r_swap_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_swap_cnt <= '0;
    else if (swap_done && (r_swap_cnt != 16'hFFFF)) r_swap_cnt <= r_swap_cnt + 16'd1;
  end
  assign swap_cnt = r_swap_cnt;
`else
  assign swap_cnt = '0;
`endif

endmodule

// File: tb/tb_quickq_node_store.sv
// Directed bench for quickq_node_store: enqueue/dequeue flows, fill/overflow,
// out-of-range access, underflow and reset during a swap.
module tb_quickq_node_store;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              re = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [2:0]        mode = 3'b100;
  logic [1:0]        mux1_sel = 2'b11;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] router_din = '0;
  logic              result, swap_done, done, full, empty, err;
  logic [DATA_W-1:0] dout;
  logic [4:0]        count;
  logic [15:0]       swap_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_swaps  = 0;

  always #5 clk = ~clk;

  quickq_node_store #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .mode(mode), .mux1_sel(mux1_sel), .din(din), .router_din(router_din),
    .result(result), .swap_done(swap_done), .done(done), .full(full), .empty(empty),
    .dout(dout), .count(count), .err(err), .swap_cnt(swap_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_temp(input logic [31:0] v);
    mode = 3'b000; mux1_sel = 2'b00; din = v;
    tick();
    mode = 3'b100; mux1_sel = 2'b11;
    $display("load temp=%h", v);
  endtask

  task automatic do_read(input int a);
    rd_addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    $display("read addr=%0d result=%0b", a, result);
  endtask

  task automatic do_swap(input int a, output int lat);
    we = 1'b1; wr_addr = a; lat = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (swap_done) begin
        lat = k;
        break;
      end
    end
    we = 1'b0;
    tick();
    if (lat != 0) n_swaps++;
    $display("swap addr=%0d lat=%0d dout=%h", a, lat, dout);
  endtask

  task automatic commit(input logic [2:0] m);
    mode = m;
    tick();
    mode = 3'b100;
    tick();
    $display("commit mode=%b count=%0d err=%0b", m, count, err);
  endtask

  // Pins the stored key exactly: temp = v-1 must be below it, temp = v must not.
  task automatic check_slot(input int a, input logic [31:0] v);
    load_temp(v - 32'd1);
    do_read(a);
    check($sformatf("slot%0d_lo", a), {31'b0, result}, 32'd1);
    load_temp(v);
    check($sformatf("slot%0d_eq", a), {31'b0, result}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #10;
    rst = 1'b1;
    $display("reset pulse");
  endtask

  function automatic logic [31:0] exp_swap_cnt();
`ifdef QUICKQ_NODE_STATS_EN
    return n_swaps;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t required end before 200000", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, ALL1);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_swap_cnt", swap_cnt, 0);
    check("rst_done", done, 1);
    rst = 1'b1;
    tick();

    load_temp(32'd5);
    do_read(3);
    check("empty_rd_result", result, 1);
    check("empty_rd_empty", empty, 1);
    check("empty_rd_count", count, 0);

    // Enqueue 7 into an empty node
    load_temp(32'd7);
    do_read(0);
    check("enq7_result", result, 1);
    do_swap(0, lat);
    check("enq7_lat", lat, 2);
    check("enq7_dout", dout, ALL1);
    commit(3'b001);
    check("enq7_count", count, 1);
    check("enq7_empty", empty, 0);
    check_slot(0, 32'd7);

    // Dequeue at count=1
    mode = 3'b010; mux1_sel = 2'b10;
    tick();
    mode = 3'b100; mux1_sel = 2'b11;
    check("deq_sent", dout, ALL1);
    do_swap(0, lat);
    check("deq_lat", lat, 2);
    check("deq_dout", dout, 7);
    commit(3'b011);
    check("deq_count", count, 0);
    check("deq_empty", empty, 1);
    check_slot(0, ALL1);

    // Enqueue 9, then 4 which evicts 9 into slot 1
    load_temp(32'd9);
    do_swap(0, lat);
    commit(3'b001);
    load_temp(32'd4);
    do_read(0);
    check("enq4_cmp0", result, 1);
    do_swap(0, lat);
    check("enq4_evict", dout, 9);
    do_read(1);
    check("enq4_cmp1", result, 1);
    do_swap(1, lat);
    check("enq4_tail_dout", dout, ALL1);
    commit(3'b001);
    check("enq4_count", count, 2);
    check_slot(0, 32'd4);
    check_slot(1, 32'd9);

    // Fill remaining slots, then overflow
    for (int i = 2; i < DEPTH; i++) begin
      load_temp(32'd100 + i);
      do_swap(i, lat);
      commit(3'b001);
    end
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_err", err, 0);
    check("fill_swap_cnt", swap_cnt, exp_swap_cnt());
    rd_addr = 15; #1;
    check("done_at15", done, 0);
    rd_addr = 16; #1;
    check("done_at16", done, 1);
    rd_addr = 0;
    commit(3'b001);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    check("ovf_err", err, 1);
    check_slot(15, 32'd115);

    // Out-of-range read
    do_reset();
    check("oor_err_clr", err, 0);
    load_temp(32'd5);
    do_read(20);
    check("oor_result", result, 1);
    check("oor_err", err, 1);

    // Underflow
    do_reset();
    commit(3'b011);
    check("udf_count", count, 0);
    check("udf_err", err, 1);

    // Reset while the FSM sits in S_WRITE
    do_reset();
    n_swaps = 0;
    load_temp(32'd7);
    we = 1'b1; wr_addr = 0;
    tick();
    rst = 1'b0;
    #2;
    check("midrst_swap_done", swap_done, 0);
    check("midrst_dout", dout, ALL1);
    we = 1'b0;
    #8;
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (swap_done) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    check("midrst_swap_cnt", swap_cnt, 0);
    check("midrst_count", count, 0);
    check_slot(0, ALL1);
    check_slot(3, ALL1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
